prog_timer: RTL and testbench
=============================

Name: prog_timer

Overview:
- Parametrised successor to the UART bit-period timer.
- Generates the baud and oversample ticks for the UART TX/RX FSMs, and general timeouts such as the RX idle/break detector.
- Adds a configurable prescaler, one-shot/periodic modes, explicit restart, a running/busy status and a readable count.
- Terminal compare is ">=", so a lowered limit never forces a full-range wrap.

Parameters:
WIDTH, 10, bit width of main counter and final_value
PRE_W, 4, bit width of prescaler counter and prescale
AUTOSTART, 1, 1: block is in RUN immediately after reset (free-running tick, legacy behaviour); 0: block is in IDLE after reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  count enable; 0 freezes prescaler and counter
start  input  1  synchronous restart/arm pulse; ignores enable
mode  input  1  0 periodic, 1 one-shot
prescale  input  PRE_W  prescaler limit P; one count step every P+1 enabled cycles
final_value  input  WIDTH  terminal value N
done  output  1  registered terminal pulse, one cycle wide
busy  output  1  1 while in RUN state
count  output  WIDTH  current main counter value

Behaviour:
Reset (reset=0, asynchronous):
- count=0, prescaler=0, done=0.
- State is RUN if AUTOSTART=1, else IDLE; busy reflects the state.
- A reset asserted mid-run aborts the run with no done pulse.

States:
- IDLE:
  - Counters hold. done=0. busy=0.
  - start=1 → RUN, with count=0 and prescaler=0.
- RUN:
  - busy=1.
  - If enable=0, all counters hold and done=0 on the next cycle.
  - Step: an edge with enable=1 where prescaler>=P. The prescaler goes to 0 on a step; otherwise it increments.
  - Terminal: a step with count>=N. count<=0 and done<=1.
    - mode=1: next state IDLE.
    - mode=0: stay in RUN.
  - Non-terminal step: count<=count+1.
  - done<=0 on every edge that is not a terminal step.
- start=1 in any state, at any edge:
  - count<=0, prescaler<=0, done<=0, state<=RUN.
  - start has priority over a simultaneous terminal event; that done is suppressed.

Timing and arithmetic:
- mode, P and N are sampled every edge; changes take effect immediately.
- Period from start (or reset with AUTOSTART) with enable held high: done is first high (N+1)(P+1) cycles after the start edge.
- Periodic mode repeats done every (N+1)(P+1) cycles.
- N=0 and P=0 in periodic mode: done high every cycle.
- Lowering N below the current count causes a terminal event on the next step (">=" compare).
- All arithmetic is unsigned, width-exact, with no overflow path. count never exceeds max(N, previous count).
- done is a flop output with no combinational path from inputs.
- busy falls on the same edge that raises done in one-shot mode.

Test Plan:
- Legacy periodic: AUTOSTART=1, P=0, N=9, enable=1 after reset release → done pulses on cycles 10, 20, 30; single-cycle width; count sequence 0..9,0.
- Prescaler: P=3, N=4, start pulse, enable=1 → first done 20 cycles after start edge; count increments every 4th cycle.
- One-shot: mode=1, P=0, N=5, start → single done 6 cycles later and busy drops on that same edge; no further done over 50 cycles; a second start produces a second done after 6 cycles.
- Enable gating: N=7, drop enable for 5 cycles at count=3 → count frozen at 3, done delayed by exactly 5 cycles, done=0 while frozen.
- Simultaneous start and terminal: assert start on the terminal edge → no done that cycle; count=0, busy=1; next done N+1 cycles later.
- Async reset mid-run: pull reset low at count=4 between edges → count=0, done=0 immediately; busy=AUTOSTART. Lowering N from 9 to 2 at count=6 → done on the next step.

Source files
------------

// File: rtl/prog_timer.sv
// Programmable tick/timeout generator: prescaler feeding a main counter with
// ">=" terminal compare, periodic or one-shot, with synchronous restart.
module prog_timer #(
  parameter int WIDTH     = 10,
  parameter int PRE_W     = 4,
  parameter bit AUTOSTART = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             mode,
  input  logic [PRE_W-1:0] prescale,
  input  logic [WIDTH-1:0] final_value,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam state_e RESET_STATE = AUTOSTART ? RUN : IDLE;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      pre_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every next-state signal gets a hold/default value before any branch,
  // which keeps this block purely combinational (no inferred latches).
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (start) begin
      // Restart wins over a coincident terminal step; its done is dropped.
      state_d = RUN;
      pre_d   = '0;
      cnt_d   = '0;
    end else if (state_q == RUN && enable) begin
      if (pre_q >= prescale) begin
        pre_d = '0;
        if (cnt_q >= final_value) begin
          cnt_d  = '0;
          done_d = 1'b1;
          if (mode) state_d = IDLE;
        end else begin
          // cnt_q < final_value here, so the increment cannot wrap.
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  assign done  = done_q;
  assign busy  = (state_q == RUN);
  assign count = cnt_q;

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: directed scenarios with hand-computed
// expectations, then randomized traffic compared every cycle to a reference model.
module tb_prog_timer;

  localparam int WIDTH = 10;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             start;
  logic             mode;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] final_value;
  logic             done, busy;
  logic [WIDTH-1:0] count;
  logic             done0, busy0;
  logic [WIDTH-1:0] count0;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  prog_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W), .AUTOSTART(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .mode(mode),
    .prescale(prescale), .final_value(final_value),
    .done(done), .busy(busy), .count(count)
  );

  prog_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W), .AUTOSTART(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .mode(mode),
    .prescale(prescale), .final_value(final_value),
    .done(done0), .busy(busy0), .count(count0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for the AUTOSTART=1 instance, stated as the rule list:
  // restart first, otherwise a running+enabled edge either finishes a prescale
  // period (step) or advances the prescaler; a step at/over the limit fires.
  int m_cnt  = 0;
  int m_pre  = 0;
  bit m_run  = 1'b1;
  bit m_done = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_pre = 0; m_run = 1'b1; m_done = 1'b0;
    end else begin
      bit fire;
      bit is_step;
      fire = 1'b0;
      is_step = m_run && enable && (m_pre >= int'(prescale));
      if (start) begin
        m_cnt = 0; m_pre = 0; m_run = 1'b1;
      end else if (m_run && enable) begin
        m_pre = is_step ? 0 : m_pre + 1;
        if (is_step) begin
          fire  = (m_cnt >= int'(final_value));
          m_cnt = fire ? 0 : m_cnt + 1;
          if (fire && mode) m_run = 1'b0;
        end
      end
      m_done = fire;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_done",  int'(done),  int'(m_done));
      check("cmp_busy",  int'(busy),  int'(m_run));
      check("cmp_count", int'(count), m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; start = 1'b0; mode = 1'b0;
    prescale = '0; final_value = 10'd9;
    cyc();
    chk_en = 1'b1;
    check("rst_count", int'(count), 0);
    check("rst_done",  int'(done),  0);
    check("rst_busy",  int'(busy),  1);
    check("rst_busy0", int'(busy0), 0);
    reset = 1'b1;

    // Legacy periodic: done on edges 10, 20, 30; count walks 0..9,0.
    for (int k = 1; k <= 30; k++) begin
      cyc();
      check("leg_done",  int'(done),  int'(k % 10 == 0));
      check("leg_count", int'(count), k % 10);
      if (k == 3) begin
        check("idle0_count", int'(count0), 0);
        check("idle0_busy",  int'(busy0),  0);
      end
    end

    // Prescaler P=3, N=4: first done 20 edges after start.
    prescale = 4'd3; final_value = 10'd4;
    pulse_start();
    check("pre_busy0", int'(busy0), 1);
    for (int k = 1; k <= 24; k++) begin
      cyc();
      check("pre_done",  int'(done),  int'(k == 20));
      check("pre_count", int'(count), (k < 20) ? k / 4 : (k - 20) / 4);
    end

    // One-shot N=5: single done 6 edges later, busy falls with it.
    prescale = 4'd0; final_value = 10'd5; mode = 1'b1;
    pulse_start();
    for (int k = 1; k <= 56; k++) begin
      cyc();
      check("os_done",  int'(done),  int'(k == 6));
      check("os_busy",  int'(busy),  int'(k < 6));
      check("os_count", int'(count), (k < 6) ? k : 0);
    end
    pulse_start();
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check("os2_done", int'(done), int'(k == 6));
      check("os2_busy", int'(busy), int'(k < 6));
    end

    // Enable gating: freeze at count=3 for 5 cycles.
    mode = 1'b0; final_value = 10'd7;
    pulse_start();
    repeat (3) cyc();
    check("gate_pre", int'(count), 3);
    enable = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check("gate_frz_count", int'(count), 3);
      check("gate_frz_done",  int'(done),  0);
    end
    enable = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      cyc();
      check("gate_done", int'(done), int'(j == 5));
    end

    // Start coincident with the terminal step suppresses done.
    final_value = 10'd3;
    pulse_start();
    repeat (3) cyc();
    check("coin_pre", int'(count), 3);
    pulse_start();
    check("coin_done",  int'(done),  0);
    check("coin_count", int'(count), 0);
    check("coin_busy",  int'(busy),  1);
    for (int j = 1; j <= 4; j++) begin
      cyc();
      check("coin_next", int'(done), int'(j == 4));
    end

    // N=0, P=0 periodic: done every cycle.
    final_value = 10'd0;
    pulse_start();
    for (int j = 1; j <= 5; j++) begin
      cyc();
      check("n0_done", int'(done), 1);
    end

    // Async reset mid-run at count=4.
    final_value = 10'd9;
    pulse_start();
    repeat (4) cyc();
    check("ar_pre", int'(count), 4);
    #2 reset = 1'b0;
    #1;
    check("ar_count", int'(count), 0);
    check("ar_done",  int'(done),  0);
    check("ar_busy",  int'(busy),  1);
    check("ar_busy0", int'(busy0), 0);
    cyc();
    reset = 1'b1;

    // Lower N from 9 to 2 at count=6: terminal on the next step.
    repeat (6) cyc();
    check("low_pre", int'(count), 6);
    final_value = 10'd2;
    cyc();
    check("low_done",  int'(done),  1);
    check("low_count", int'(count), 0);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      start  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) begin
        mode        = 1'($urandom_range(0, 1));
        prescale    = 4'($urandom_range(0, 3));
        final_value = 10'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 199) == 0) final_value = 10'($urandom_range(0, 2));
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        #2 reset = 1'b1;
      end
      cyc();
    end
    start = 1'b0;
    cyc();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
